// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls
// upstream until the memory answers, and latches results into the MEM/WB register.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_mem_valid,
  input  logic [31:0] ex_mem_ir,
  input  logic [31:0] ex_mem_cond,
  input  logic [31:0] ex_mem_alu,
  input  logic [31:0] ex_mem_b,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        mem_wb_valid,
  output logic [31:0] mem_wb_ir,
  output logic [31:0] mem_wb_alu,
  output logic [31:0] mem_wb_lmd,
  output logic        mem_wb_fault
);

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        mem_wb_valid_q, mem_wb_valid_d;
  logic [31:0] mem_wb_ir_q, mem_wb_ir_d;
  logic [31:0] mem_wb_alu_q, mem_wb_alu_d;
  logic [31:0] mem_wb_lmd_q, mem_wb_lmd_d;
  logic        mem_wb_fault_q, mem_wb_fault_d;

  logic [2:0]  funct3;
  logic        is_load, is_store, is_mem;
  logic        f3_legal, misaligned, access_ok;

  // The branch condition is carried by the latch but has no role in this stage.
  logic unused_cond;
  assign unused_cond = ^ex_mem_cond;

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      3'b000:  store_be = 4'b0001 << lo;
      3'b001:  store_be = 4'b0011 << lo;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] b);
    case (f3)
      3'b000:  store_data = {4{b[7:0]}};
      3'b001:  store_data = {2{b[15:0]}};
      default: store_data = b;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = rdata[{lo, 3'b000} +: 8];
    half_v = lo[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  load_extract = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_extract = {24'd0, byte_v};
      3'b001:  load_extract = {{16{half_v[15]}}, half_v};
      3'b101:  load_extract = {16'd0, half_v};
      default: load_extract = rdata;
    endcase
  endfunction

  assign funct3   = ex_mem_ir[14:12];
  assign is_load  = (ex_mem_ir[6:0] == OPC_LOAD);
  assign is_store = (ex_mem_ir[6:0] == OPC_STORE);
  assign is_mem   = is_load | is_store;

  // Legality and alignment of the requested access size.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      3'b000:  f3_legal = is_mem;
      3'b001: begin
        f3_legal   = is_mem;
        misaligned = ex_mem_alu[0];
      end
      3'b010: begin
        f3_legal   = is_mem;
        misaligned = (ex_mem_alu[1:0] != 2'b00);
      end
      3'b100:  f3_legal = is_load;
      3'b101: begin
        f3_legal   = is_load;
        misaligned = ex_mem_alu[0];
      end
      default: f3_legal = 1'b0;
    endcase
  end

  assign access_ok = f3_legal & ~misaligned;

  // The upstream latch is frozen while stalled, so the request fields can be
  // derived straight from the ex_mem inputs and stay constant across ACCESS.
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & is_store;
  assign dmem_addr  = {ex_mem_alu[31:2], 2'b00};
  assign dmem_be    = is_store ? store_be(funct3, ex_mem_alu[1:0]) : 4'b1111;
  assign dmem_wdata = store_data(funct3, ex_mem_b);

  // Next-state, MEM/WB update and stall generation.
  always_comb begin
    state_d        = state_q;
    mem_wb_valid_d = mem_wb_valid_q;
    mem_wb_ir_d    = mem_wb_ir_q;
    mem_wb_alu_d   = mem_wb_alu_q;
    mem_wb_lmd_d   = mem_wb_lmd_q;
    mem_wb_fault_d = mem_wb_fault_q;
    mem_stall      = 1'b0;
    if (reset) begin
      state_d        = IDLE;
      mem_wb_valid_d = 1'b0;
      mem_wb_ir_d    = 32'd0;
      mem_wb_alu_d   = 32'd0;
      mem_wb_lmd_d   = 32'd0;
      mem_wb_fault_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!ex_mem_valid) begin
            mem_wb_valid_d = 1'b0;
          end else if (is_mem && access_ok) begin
            mem_stall      = 1'b1;
            mem_wb_valid_d = 1'b0;
            state_d        = ACCESS;
          end else begin
            // Non-memory op, or a load/store that faults without touching memory.
            mem_wb_valid_d = 1'b1;
            mem_wb_ir_d    = ex_mem_ir;
            mem_wb_alu_d   = ex_mem_alu;
            mem_wb_lmd_d   = 32'd0;
            mem_wb_fault_d = is_mem;
          end
        end
        ACCESS: begin
          mem_stall = ~dmem_ready;
          if (dmem_ready) begin
            state_d        = IDLE;
            mem_wb_valid_d = 1'b1;
            mem_wb_ir_d    = ex_mem_ir;
            mem_wb_alu_d   = ex_mem_alu;
            mem_wb_lmd_d   = is_load ? load_extract(funct3, ex_mem_alu[1:0], dmem_rdata) : 32'd0;
            mem_wb_fault_d = 1'b0;
          end else begin
            mem_wb_valid_d = 1'b0;
          end
        end
        default: begin
          state_d        = IDLE;
          mem_wb_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and MEM/WB registers.
  always_ff @(posedge clk) begin
    state_q        <= state_d;
    mem_wb_valid_q <= mem_wb_valid_d;
    mem_wb_ir_q    <= mem_wb_ir_d;
    mem_wb_alu_q   <= mem_wb_alu_d;
    mem_wb_lmd_q   <= mem_wb_lmd_d;
    mem_wb_fault_q <= mem_wb_fault_d;
  end

  assign mem_wb_valid = mem_wb_valid_q;
  assign mem_wb_ir    = mem_wb_ir_q;
  assign mem_wb_alu   = mem_wb_alu_q;
  assign mem_wb_lmd   = mem_wb_lmd_q;
  assign mem_wb_fault = mem_wb_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, faults, waits and
// reset in the middle of an access, with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_ir, ex_mem_cond, ex_mem_alu, ex_mem_b;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        mem_wb_valid, mem_wb_fault;
  logic [31:0] mem_wb_ir, mem_wb_alu, mem_wb_lmd;

  int checks = 0;
  int errors = 0;
  int stall_cycles;

  localparam logic [31:0] IR_ADD  = 32'h0020_8033;
  localparam logic [31:0] IR_LB   = 32'h0000_0083;
  localparam logic [31:0] IR_LW   = 32'h0000_2083;
  localparam logic [31:0] IR_LHU  = 32'h0000_5083;
  localparam logic [31:0] IR_LBAD = 32'h0000_3083;
  localparam logic [31:0] IR_SB   = 32'h0000_0023;
  localparam logic [31:0] IR_SH   = 32'h0000_1023;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_mem_valid(ex_mem_valid), .ex_mem_ir(ex_mem_ir), .ex_mem_cond(ex_mem_cond),
    .ex_mem_alu(ex_mem_alu), .ex_mem_b(ex_mem_b),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_ir(mem_wb_ir),
    .mem_wb_alu(mem_wb_alu), .mem_wb_lmd(mem_wb_lmd), .mem_wb_fault(mem_wb_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] alu,
                       input logic [31:0] b);
    ex_mem_valid = v;
    ex_mem_ir    = ir;
    ex_mem_alu   = alu;
    ex_mem_b     = b;
    #1;
  endtask

  initial begin
    reset = 1'b1; ex_mem_valid = 1'b0; ex_mem_ir = 32'd0; ex_mem_cond = 32'hDEAD_BEEF;
    ex_mem_alu = 32'd0; ex_mem_b = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_valid", mem_wb_valid, 32'd0);
    check("rst_fault", mem_wb_fault, 32'd0);
    check("rst_lmd", mem_wb_lmd, 32'd0);
    check("rst_ir", mem_wb_ir, 32'd0);
    check("rst_req", dmem_req, 32'd0);
    check("rst_stall", mem_stall, 32'd0);

    // Non-memory pass-through
    drive(1'b1, IR_ADD, 32'h5, 32'h0);
    check("add_stall", mem_stall, 32'd0);
    check("add_req", dmem_req, 32'd0);
    tick();
    check("add_valid", mem_wb_valid, 32'd1);
    check("add_alu", mem_wb_alu, 32'h5);
    check("add_ir", mem_wb_ir, IR_ADD);
    check("add_lmd", mem_wb_lmd, 32'd0);
    check("add_fault", mem_wb_fault, 32'd0);

    // Bubble, with a stray ready in IDLE that must be ignored
    dmem_ready = 1'b1;
    drive(1'b0, IR_ADD, 32'h5, 32'h0);
    check("bub_req", dmem_req, 32'd0);
    tick();
    check("bub_valid", mem_wb_valid, 32'd0);
    check("bub_req2", dmem_req, 32'd0);
    dmem_ready = 1'b0;

    // LB, zero wait
    drive(1'b1, IR_LB, 32'h1003, 32'h0);
    check("lb_stall_entry", mem_stall, 32'd1);
    check("lb_req_entry", dmem_req, 32'd0);
    tick();
    check("lb_req", dmem_req, 32'd1);
    check("lb_we", dmem_we, 32'd0);
    check("lb_addr", dmem_addr, 32'h1000);
    check("lb_be", dmem_be, 32'hF);
    check("lb_valid_mid", mem_wb_valid, 32'd0);
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    check("lb_stall_ready", mem_stall, 32'd0);
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, IR_ADD, 32'h0, 32'h0);
    check("lb_valid", mem_wb_valid, 32'd1);
    check("lb_lmd", mem_wb_lmd, 32'hFFFF_FF80);
    check("lb_fault", mem_wb_fault, 32'd0);
    check("lb_req_after", dmem_req, 32'd0);

    // SH with three wait cycles
    stall_cycles = 0;
    drive(1'b1, IR_SH, 32'h2002, 32'hAAAA_BEEF);
    if (mem_stall) stall_cycles++;
    tick();
    check("sh_req", dmem_req, 32'd1);
    check("sh_we", dmem_we, 32'd1);
    check("sh_addr", dmem_addr, 32'h2000);
    check("sh_be", dmem_be, 32'hC);
    check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    for (int i = 0; i < 3; i++) begin
      if (mem_stall) stall_cycles++;
      check("sh_wait_valid", mem_wb_valid, 32'd0);
      tick();
    end
    check("sh_be_held", dmem_be, 32'hC);
    dmem_ready = 1'b1;
    #1;
    if (mem_stall) stall_cycles++;
    check("sh_stall_cycles", stall_cycles, 32'd4);
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, IR_ADD, 32'h0, 32'h0);
    check("sh_valid", mem_wb_valid, 32'd1);
    check("sh_lmd", mem_wb_lmd, 32'd0);
    check("sh_ir", mem_wb_ir, IR_SH);

    // Misaligned LW faults without a request
    drive(1'b1, IR_LW, 32'h3001, 32'h0);
    check("mis_req", dmem_req, 32'd0);
    check("mis_stall", mem_stall, 32'd0);
    tick();
    check("mis_valid", mem_wb_valid, 32'd1);
    check("mis_fault", mem_wb_fault, 32'd1);
    check("mis_lmd", mem_wb_lmd, 32'd0);
    check("mis_req2", dmem_req, 32'd0);

    // Illegal funct3 on a load opcode
    drive(1'b1, IR_LBAD, 32'h0, 32'h0);
    check("bad_stall", mem_stall, 32'd0);
    tick();
    check("bad_fault", mem_wb_fault, 32'd1);
    check("bad_req", dmem_req, 32'd0);

    // SB at byte 1
    drive(1'b1, IR_SB, 32'h7001, 32'h1234_5678);
    tick();
    check("sb_be", dmem_be, 32'h2);
    check("sb_wdata", dmem_wdata, 32'h7878_7878);
    check("sb_addr", dmem_addr, 32'h7000);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    check("sb_fault", mem_wb_fault, 32'd0);

    // Reset in the second ACCESS cycle while ready is high
    drive(1'b1, IR_LW, 32'h5000, 32'h0);
    tick();
    check("rma_req1", dmem_req, 32'd1);
    tick();
    reset = 1'b1; dmem_ready = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    reset = 1'b0; dmem_ready = 1'b0;
    drive(1'b0, IR_ADD, 32'h0, 32'h0);
    check("rma_req", dmem_req, 32'd0);
    check("rma_valid", mem_wb_valid, 32'd0);
    check("rma_lmd", mem_wb_lmd, 32'd0);
    check("rma_stall", mem_stall, 32'd0);

    // LHU, upper halfword, ready already high at entry
    dmem_ready = 1'b1; dmem_rdata = 32'h9ABC_0000;
    drive(1'b1, IR_LHU, 32'h4002, 32'h0);
    check("lhu_stall_entry", mem_stall, 32'd1);
    tick();
    check("lhu_req", dmem_req, 32'd1);
    check("lhu_be", dmem_be, 32'hF);
    tick();
    dmem_ready = 1'b0;
    drive(1'b0, IR_ADD, 32'h0, 32'h0);
    check("lhu_valid", mem_wb_valid, 32'd1);
    check("lhu_lmd", mem_wb_lmd, 32'h0000_9ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
